// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
package fifo_pkg;

    // Per-cycle request, indexed by {push_i, pop_i}.
    typedef enum logic [1:0] {
        NOP      = 2'b00,
        POP      = 2'b01,
        PUSH     = 2'b10,
        PUSH_POP = 2'b11
    } op_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register; wraps DEPTH-1 -> 0 with no power-of-two assumption.
module fifo_ptr #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer: clear wins over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy, almost-full/empty thresholds and sticky error flags.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter  int          WIDTH    = 8,
    parameter  int          DEPTH    = 16,
    parameter  int          AF_LEVEL = DEPTH - 2,
    parameter  int          AE_LEVEL = 2,
    localparam int unsigned CW       = cnt_width(DEPTH),
    localparam int unsigned PW       = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             clr_err_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;
    logic             ovf_evt;
    logic             unf_evt;
    op_t              op;

    assign op       = op_t'({push_i, pop_i});
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // Decode request into accepted push/pop and error events; flush suppresses all.
    // On full, a simultaneous pop frees the slot so the push is accepted.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (!flush_i) begin
            case (op)
                POP: begin
                    if (is_empty) unf_evt = 1'b1;
                    else          do_pop  = 1'b1;
                end
                PUSH: begin
                    if (is_full) ovf_evt = 1'b1;
                    else         do_push = 1'b1;
                end
                PUSH_POP: begin
                    do_push = 1'b1;
                    if (is_empty) unf_evt = 1'b1;
                    else          do_pop  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next occupancy and sticky error flags; a same-cycle event beats clr_err_i.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        ovf_d = ovf_evt | (ovf_q & ~clr_err_i);
        unf_d = unf_evt | (unf_q & ~clr_err_i);
    end

    // Occupancy and error flag registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; cleared on reset, written on accepted push only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr] <= din_i;
        end
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (do_push),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (do_pop),
        .ptr_o (rd_ptr)
    );

    assign dout_o         = mem_q[rd_ptr];
    assign count_o        = count_q;
    assign full_o         = is_full;
    assign empty_o        = is_empty;
    assign almost_full_o  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty_o = (int'(count_q) <= AE_LEVEL);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: DEPTH=16 main instance plus a DEPTH=5 wrap instance.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // DEPTH=16 instance
    logic       a_flush = 1'b0, a_clr = 1'b0, a_push = 1'b0, a_pop = 1'b0;
    logic [7:0] a_din = '0;
    logic [7:0] a_dout;
    logic [4:0] a_cnt;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

    // DEPTH=5 instance
    logic       b_flush = 1'b0, b_clr = 1'b0, b_push = 1'b0, b_pop = 1'b0;
    logic [7:0] b_din = '0;
    logic [7:0] b_dout;
    logic [2:0] b_cnt;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fifo_sync_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .clr_err_i(a_clr),
        .push_i(a_push), .din_i(a_din), .pop_i(a_pop), .dout_o(a_dout),
        .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae),
        .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    fifo_sync_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .clr_err_i(b_clr),
        .push_i(b_push), .din_i(b_din), .pop_i(b_pop), .dout_o(b_dout),
        .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae),
        .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    // One clock on instance A; inputs return to idle afterwards.
    task automatic step_a(input logic ps, input logic pp, input logic [7:0] d,
                          input logic fl, input logic ce);
        a_push = ps; a_pop = pp; a_din = d; a_flush = fl; a_clr = ce;
        @(posedge clk); #1;
        a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
    endtask

    task automatic step_b(input logic ps, input logic pp, input logic [7:0] d);
        b_push = ps; b_pop = pp; b_din = d;
        @(posedge clk); #1;
        b_push = 1'b0; b_pop = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (a_cnt !== 5'd0) $display("FAIL rst_count: got %0d want 0", a_cnt); else passes++;
        checks++; if (a_empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", a_empty); else passes++;
        checks++; if (a_full !== 1'b0) $display("FAIL rst_full: got %b want 0", a_full); else passes++;
        checks++; if (a_ae !== 1'b1 || a_af !== 1'b0) $display("FAIL rst_almost: got ae=%b af=%b want 1 0", a_ae, a_af); else passes++;
        checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) $display("FAIL rst_err: got ovf=%b unf=%b want 0 0", a_ovf, a_unf); else passes++;
        checks++; if (a_dout !== 8'h00) $display("FAIL rst_dout: got %0h want 0", a_dout); else passes++;
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            step_a(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            checks++; if (a_cnt !== 5'(i)) $display("FAIL fill_count: got %0d want %0d", a_cnt, i); else passes++;
            checks++; if (a_dout !== 8'h01) $display("FAIL fill_dout: got %0h want 1", a_dout); else passes++;
            checks++; if (a_full !== (i == 16)) $display("FAIL fill_full: got %b at count %0d", a_full, i); else passes++;
            checks++; if (a_af !== (i >= 14)) $display("FAIL fill_af: got %b at count %0d", a_af, i); else passes++;
            checks++; if (a_ae !== (i <= 2)) $display("FAIL fill_ae: got %b at count %0d", a_ae, i); else passes++;
        end
    endtask

    task automatic test_overflow_drain;
        step_a(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        checks++; if (a_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", a_ovf); else passes++;
        checks++; if (a_cnt !== 5'd16) $display("FAIL ovf_count: got %0d want 16", a_cnt); else passes++;
        for (int i = 1; i <= 16; i++) begin
            checks++; if (a_dout !== 8'(i)) $display("FAIL drain_dout: got %0h want %0h", a_dout, i); else passes++;
            step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            checks++; if (a_cnt !== 5'(16 - i)) $display("FAIL drain_count: got %0d want %0d", a_cnt, 16 - i); else passes++;
        end
        checks++; if (a_empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", a_empty); else passes++;
    endtask

    task automatic test_underflow_clear;
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (a_unf !== 1'b1) $display("FAIL unf_flag: got %b want 1", a_unf); else passes++;
        checks++; if (a_cnt !== 5'd0) $display("FAIL unf_count: got %0d want 0", a_cnt); else passes++;
        step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (a_unf !== 1'b0 || a_ovf !== 1'b0) $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", a_ovf, a_unf); else passes++;
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        checks++; if (a_unf !== 1'b1) $display("FAIL clr_vs_event: got %b want 1", a_unf); else passes++;
        step_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_push_pop_full;
        for (int i = 1; i <= 16; i++) step_a(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        checks++; if (a_cnt !== 5'd16) $display("FAIL pp_full_count: got %0d want 16", a_cnt); else passes++;
        checks++; if (a_ovf !== 1'b0) $display("FAIL pp_full_ovf: got %b want 0", a_ovf); else passes++;
        checks++; if (a_full !== 1'b1) $display("FAIL pp_full_full: got %b want 1", a_full); else passes++;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp;
            exp = (i < 15) ? 8'(8'h22 + i) : 8'hAA;
            checks++; if (a_dout !== exp) $display("FAIL pp_full_order: got %0h want %0h", a_dout, exp); else passes++;
            step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        checks++; if (a_empty !== 1'b1) $display("FAIL pp_full_empty: got %b want 1", a_empty); else passes++;
    endtask

    task automatic test_push_pop_empty;
        step_a(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        checks++; if (a_cnt !== 5'd1) $display("FAIL pp_empty_count: got %0d want 1", a_cnt); else passes++;
        checks++; if (a_dout !== 8'h55) $display("FAIL pp_empty_dout: got %0h want 55", a_dout); else passes++;
        checks++; if (a_unf !== 1'b1) $display("FAIL pp_empty_unf: got %b want 1", a_unf); else passes++;
        checks++; if (a_empty !== 1'b0) $display("FAIL pp_empty_empty: got %b want 0", a_empty); else passes++;
    endtask

    task automatic test_wrap;
        logic [7:0] q[$];
        logic       ovf_m;
        logic [7:0] d;
        bit         ps, pp;
        ovf_m = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 40; i++) begin
            ps = (i % 4) != 3;
            pp = (i % 4) >= 2;
            d = d + 8'h01;
            if (ps && pp) begin
                if (q.size() > 0) void'(q.pop_front());
                q.push_back(d);
            end else if (ps) begin
                if (q.size() < 5) q.push_back(d);
                else ovf_m = 1'b1;
            end else if (pp) begin
                if (q.size() > 0) void'(q.pop_front());
            end
            step_b(ps, pp, d);
            checks++; if (b_cnt !== 3'(q.size())) $display("FAIL wrap_count: got %0d want %0d at cycle %0d", b_cnt, q.size(), i); else passes++;
            checks++; if (b_cnt > 3'd5) $display("FAIL wrap_bound: got %0d want <=5", b_cnt); else passes++;
            if (q.size() > 0) begin
                checks++; if (b_dout !== q[0]) $display("FAIL wrap_dout: got %0h want %0h at cycle %0d", b_dout, q[0], i); else passes++;
            end
            checks++; if (b_ovf !== ovf_m) $display("FAIL wrap_ovf: got %b want %b at cycle %0d", b_ovf, ovf_m, i); else passes++;
        end
        checks++; if (b_full !== (q.size() == 5)) $display("FAIL wrap_full: got %b want %b", b_full, q.size() == 5); else passes++;
    endtask

    task automatic test_flush;
        step_a(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step_a(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        checks++; if (a_cnt !== 5'd10) $display("FAIL flush_prefill: got %0d want 10", a_cnt); else passes++;
        step_a(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        checks++; if (a_cnt !== 5'd0) $display("FAIL flush_count: got %0d want 0", a_cnt); else passes++;
        checks++; if (a_empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", a_empty); else passes++;
        checks++; if (a_unf !== 1'b1 || a_ovf !== 1'b0) $display("FAIL flush_err: got ovf=%b unf=%b want 0 1", a_ovf, a_unf); else passes++;
        step_a(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        checks++; if (a_dout !== 8'h33 || a_cnt !== 5'd1) $display("FAIL flush_after: got dout=%0h cnt=%0d want 33 1", a_dout, a_cnt); else passes++;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 8'(8'h90 + i), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++; if (a_cnt !== 5'd0 || b_cnt !== 3'd0) $display("FAIL arst_count: got a=%0d b=%0d want 0 0", a_cnt, b_cnt); else passes++;
        checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) $display("FAIL arst_flags: got empty=%b full=%b want 1 0", a_empty, a_full); else passes++;
        checks++; if (a_dout !== 8'h00) $display("FAIL arst_dout: got %0h want 0", a_dout); else passes++;
        checks++; if (a_unf !== 1'b0 || a_ovf !== 1'b0 || b_ovf !== 1'b0) $display("FAIL arst_err: got a_ovf=%b a_unf=%b b_ovf=%b want 0", a_ovf, a_unf, b_ovf); else passes++;
        checks++; if (a_ae !== 1'b1 || a_af !== 1'b0) $display("FAIL arst_almost: got ae=%b af=%b want 1 0", a_ae, a_af); else passes++;
        @(negedge clk);
        rst = 1'b1;
        step_a(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        checks++; if (a_cnt !== 5'd1 || a_dout !== 8'hC3) $display("FAIL arst_first_op: got cnt=%0d dout=%0h want 1 c3", a_cnt, a_dout); else passes++;
    endtask

    initial begin
        #2;
        test_reset;
        #10 rst = 1'b1;
        test_fill;
        test_overflow_drain;
        test_underflow_clear;
        test_push_pop_full;
        test_push_pop_empty;
        test_wrap;
        test_flush;
        test_async_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
